// File: rtl/cache_defs.sv
// Shared I-cache geometry and the structs/enums used on the cache refill interface.
package cache_defs;

  localparam int ICACHE_LINE_WIDTH  = 128;
  localparam int ICACHE_OFFSET_BITS = $clog2(ICACHE_LINE_WIDTH / 8);

  typedef struct packed {
    logic [31:0] addr;
    logic        req;
    logic        kill;
  } type_icache2mem_s;

  typedef struct packed {
    logic [ICACHE_LINE_WIDTH-1:0] r_data;
    logic                         ack;
  } type_mem2icache_s;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_FETCH,
    FILL_DRAIN,
    FILL_RESP
  } type_icache_fill_states_e;

endpackage

// File: rtl/icache_line_fill.sv
// I-cache refill responder: fetches one cache line as sequential word reads and
// returns it to the cache with a one-cycle ack; a killed or dropped request is abandoned.
//
// state      | meaning
// FILL_IDLE  | waiting for req & ~kill from the cache
// FILL_FETCH | issuing word reads, assembling the line
// FILL_DRAIN | request abandoned, letting the in-flight word read complete
// FILL_RESP  | line returned, ack high for this single cycle
module icache_line_fill
  import cache_defs::*;
#(
  parameter int LINE_W     = ICACHE_LINE_WIDTH,
  parameter int MEM_DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  type_icache2mem_s      icache2mem_i,
  output type_mem2icache_s      mem2icache_o,
  output logic                  mem_req_o,
  output logic [31:0]           mem_addr_o,
  input  logic [MEM_DATA_W-1:0] mem_rdata_i,
  input  logic                  mem_ack_i
);

  localparam int BEATS  = LINE_W / MEM_DATA_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int BYTE_W = $clog2(MEM_DATA_W / 8);
  localparam int OFF_W  = BEAT_W + BYTE_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  type_icache_fill_states_e state;
  logic [31-OFF_W:0]        line_addr;
  logic [BEAT_W-1:0]        beat;
  logic [LINE_W-1:0]        line_buf;
  logic [LINE_W-1:0]        line_next;
  logic [LINE_W-1:0]        r_data;
  logic                     ack;
  logic                     abandon;
  logic                     unused_addr_bits;

  // The cache drops req without kill on a boot-region redirect; both mean abandon.
  assign abandon          = icache2mem_i.kill | ~icache2mem_i.req;
  assign unused_addr_bits = ^icache2mem_i.addr[OFF_W-1:0];

  always_comb begin
    line_next = line_buf;
    line_next[beat*MEM_DATA_W +: MEM_DATA_W] = mem_rdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL_IDLE;
      line_addr <= '0;
      beat      <= '0;
      line_buf  <= '0;
      r_data    <= '0;
      ack       <= 1'b0;
      mem_req_o <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        FILL_IDLE: begin
          if (icache2mem_i.req && !icache2mem_i.kill) begin
            line_addr <= icache2mem_i.addr[31:OFF_W];
            beat      <= '0;
            mem_req_o <= 1'b1;
            state     <= FILL_FETCH;
          end
        end
        FILL_FETCH: begin
          if (mem_ack_i && abandon) begin
            mem_req_o <= 1'b0;
            state     <= FILL_IDLE;
          end else if (mem_ack_i) begin
            line_buf <= line_next;
            if (beat == LAST_BEAT) begin
              r_data    <= line_next;
              ack       <= 1'b1;
              mem_req_o <= 1'b0;
              state     <= FILL_RESP;
            end else begin
              beat <= beat + 1'b1;
            end
          end else if (abandon) begin
            state <= FILL_DRAIN;
          end
        end
        FILL_DRAIN: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= FILL_IDLE;
          end
        end
        FILL_RESP: begin
          state <= FILL_IDLE;
        end
        default: begin
          mem_req_o <= 1'b0;
          state     <= FILL_IDLE;
        end
      endcase
    end
  end

  assign mem_addr_o          = {line_addr, beat, {BYTE_W{1'b0}}};
  assign mem2icache_o.r_data = r_data;
  assign mem2icache_o.ack    = ack;

endmodule

// File: tb/tb_icache_line_fill.sv
// Bench for icache_line_fill: directed vector table, random fills against a line-level model,
// plus hand sequences for back-to-back requests and asynchronous reset.
module tb_icache_line_fill;
  import cache_defs::*;

  typedef struct {
    logic [31:0]     addr;
    bit [3:0][7:0]   w;
    logic [127:0]    line;
    int              abort_beat;
    bit              abort_kill;
    bit              abort_coinc;
    bit              exp_ack;
    int              exp_lat;
  } vec_t;

  logic             clk;
  logic             rst_n;
  type_icache2mem_s icache2mem;
  type_mem2icache_s mem2icache;
  logic             mem_req_o;
  logic [31:0]      mem_addr_o;
  logic [31:0]      mem_rdata_i;
  logic             mem_ack_i;

  int               n_err;
  int               n_chk;
  logic [127:0]     model_r;
  logic [127:0]     model_buf;
  vec_t             vecs[7];

  icache_line_fill dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .icache2mem_i (icache2mem),
    .mem2icache_o (mem2icache),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_i(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply_abort(input vec_t v);
    if (v.abort_kill) icache2mem.kill = 1'b1;
    else              icache2mem.req  = 1'b0;
  endtask

  // Drives one line request and acts as a word memory with per-beat wait states.
  task automatic run_vec(input vec_t v, input int exp_first, input bit hold,
                         input logic [31:0] next_addr);
    int c, k, wait_cnt, ack_c, first_c, req_cyc, n_ack, sumw, budget, exp_req, exp_n;
    bit aborted;
    logic [127:0] got_r;
    logic [31:0]  addrs[$];
    wait_cnt = 0; ack_c = -1; first_c = -1; req_cyc = 0; n_ack = 0; sumw = 0;
    aborted = 0; got_r = '0;
    for (int i = 0; i < 4; i++) sumw += int'(v.w[i]);
    budget = 10 + sumw;
    icache2mem.addr = v.addr;
    icache2mem.req  = 1'b1;
    icache2mem.kill = 1'b0;
    for (c = 1; c <= budget; c++) begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (mem2icache.ack) begin
        n_ack++;
        if (ack_c < 0) ack_c = c;
        got_r = mem2icache.r_data;
      end
      if (mem_req_o) begin
        req_cyc++;
        if (first_c < 0) first_c = c;
        k = int'(mem_addr_o[3:2]);
        if (wait_cnt < int'(v.w[k])) begin
          wait_cnt++;
          if (!aborted && k == v.abort_beat && !v.abort_coinc) begin
            aborted = 1;
            apply_abort(v);
          end
        end else begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = v.line[k*32 +: 32];
          addrs.push_back(mem_addr_o);
          wait_cnt = 0;
          if (!aborted && k == v.abort_beat && v.abort_coinc) begin
            aborted = 1;
            apply_abort(v);
          end
        end
      end
      if (mem2icache.ack) begin
        if (hold) begin
          icache2mem.addr = next_addr;
          break;
        end
        icache2mem.req = 1'b0;
      end
    end

    chk_i("first_req_cycle", first_c, exp_first);
    if (v.exp_ack) begin
      chk_i("ack_cycle", ack_c, v.exp_lat + exp_first - 1);
      chk_i("ack_count", n_ack, 1);
      chk_v("r_data", got_r, v.line);
      model_r   = v.line;
      model_buf = v.line;
      exp_req   = 4 + sumw;
      exp_n     = 4;
    end else begin
      chk_i("ack_count_abandon", n_ack, 0);
      chk_v("r_data_held", mem2icache.r_data, model_r);
      for (int i = 0; i < v.abort_beat; i++) model_buf[i*32 +: 32] = v.line[i*32 +: 32];
      exp_req = 0;
      for (int i = 0; i <= v.abort_beat; i++) exp_req += int'(v.w[i]) + 1;
      exp_n = v.abort_beat + 1;
    end
    chk_v("line_buf", dut.line_buf, model_buf);
    chk_i("req_cycles", req_cyc, exp_req);
    chk_i("addr_count", addrs.size(), exp_n);
    for (int i = 0; i < addrs.size() && i < exp_n; i++)
      chk_v("mem_addr", 128'(addrs[i]), 128'({v.addr[31:4], 4'(i * 4)}));
    mem_ack_i = 1'b0;
    if (!hold) begin
      chk_i("idle_req_low", int'(mem_req_o), 0);
      icache2mem.req  = 1'b0;
      icache2mem.kill = 1'b0;
    end
  endtask

  task automatic reset_mid_fill();
    logic [127:0] line;
    line = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
    icache2mem.addr = 32'h8000_5000;
    icache2mem.req  = 1'b1;
    icache2mem.kill = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      mem_ack_i   = (c <= 3);
      mem_rdata_i = line[(c-1)*32 +: 32];
    end
    chk_i("rst_pre_req", int'(mem_req_o), 1);
    chk_v("rst_pre_addr", 128'(mem_addr_o), 128'(32'h8000_500C));
    rst_n = 1'b0;
    #1;
    chk_i("rst_req", int'(mem_req_o), 0);
    chk_i("rst_ack", int'(mem2icache.ack), 0);
    chk_v("rst_r_data", mem2icache.r_data, '0);
    chk_v("rst_addr", 128'(mem_addr_o), '0);
    chk_v("rst_line_buf", dut.line_buf, '0);
    mem_ack_i      = 1'b0;
    icache2mem.req = 1'b0;
    model_r   = '0;
    model_buf = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t rv;
    int   sumw;
    n_err = 0; n_chk = 0;
    model_r = '0; model_buf = '0;
    rst_n = 1'b0;
    icache2mem = '0;
    mem_rdata_i = '0;
    mem_ack_i = 1'b0;

    vecs[0] = '{32'h8000_1234, {8'd0, 8'd0, 8'd0, 8'd0},
                128'h44444444_33333333_22222222_11111111, -1, 0, 0, 1, 5};
    vecs[1] = '{32'h0000_2008, {8'd2, 8'd2, 8'd2, 8'd2},
                128'h0F0F0F0F_A5A5A5A5_12345678_DEADBEEF, -1, 0, 0, 1, 13};
    vecs[2] = '{32'h1234_5670, {8'd0, 8'd3, 8'd1, 8'd1},
                128'h99990003_99990002_99990001_99990000, 2, 1, 0, 0, 0};
    vecs[3] = '{32'hCAFE_0010, {8'd0, 8'd0, 8'd1, 8'd0},
                128'h77770003_77770002_77770001_77770000, 1, 0, 1, 0, 0};
    vecs[4] = '{32'h0000_0FF0, {8'd0, 8'd1, 8'd0, 8'd3},
                128'hC0DE0004_C0DE0003_C0DE0002_C0DE0001, -1, 0, 0, 1, 9};
    vecs[5] = '{32'hFFFF_FFFC, {8'd0, 8'd0, 8'd0, 8'd0},
                128'h55550003_55550002_55550001_55550000, 3, 1, 1, 0, 0};
    vecs[6] = '{32'h4000_0020, {8'd0, 8'd0, 8'd0, 8'd2},
                128'h66660003_66660002_66660001_66660000, 0, 0, 0, 0, 0};

    repeat (2) @(negedge clk);
    chk_i("reset_req", int'(mem_req_o), 0);
    chk_i("reset_ack", int'(mem2icache.ack), 0);
    chk_v("reset_r_data", mem2icache.r_data, '0);
    chk_v("reset_addr", 128'(mem_addr_o), '0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_vec(vecs[i], 1, 0, '0);
      @(negedge clk);
    end

    // Back-to-back: req stays high through the first ack with the next address presented.
    run_vec(vecs[1], 1, 1, 32'h0BAD_F00C);
    rv = vecs[4];
    rv.addr = 32'h0BAD_F00C;
    run_vec(rv, 2, 0, '0);
    @(negedge clk);

    reset_mid_fill();
    rv = vecs[0];
    rv.addr = 32'h0000_0040;
    rv.line = 128'h40400003_40400002_40400001_40400000;
    run_vec(rv, 1, 0, '0);
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      sumw = 0;
      rv.addr = $urandom;
      rv.line = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 4; i++) rv.w[i] = 8'($urandom_range(0, 3));
      rv.abort_beat  = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 3)) : -1;
      rv.abort_kill  = 1'($urandom_range(0, 1));
      rv.abort_coinc = 1'($urandom_range(0, 1));
      if (rv.abort_beat >= 0 && !rv.abort_coinc && rv.w[rv.abort_beat] == 0)
        rv.w[rv.abort_beat] = 8'd1;
      for (int i = 0; i < 4; i++) sumw += int'(rv.w[i]);
      rv.exp_ack = (rv.abort_beat < 0);
      rv.exp_lat = 5 + sumw;
      run_vec(rv, 1, 0, '0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
